// File: rtl/grey_col_conv.sv
// grey_col_conv: takes one packed-RGB image column per handshake and converts it to greyscale
// with LANES shared converters over N/LANES cycles. Counts columns handed off within a frame.
module grey_col_conv #(
  parameter int N     = 256,
  parameter int LANES = 32,
  parameter int CW    = 8,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [N*3*CW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [N*CW-1:0]   out_data,
  output logic [CNT_W-1:0]  col_count
);

  localparam int P  = N / LANES;
  localparam int GW = (P > 1) ? $clog2(P) : 1;
  localparam int PW = 3 * CW;
  localparam logic [GW-1:0] G_LAST = GW'(P - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [GW-1:0]       g_r;
  logic [N*PW-1:0]     data_r;
  logic [1:0]          mode_r;
  logic                last_r;
  logic [N*CW-1:0]     out_data_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                accept_s, handoff_s, in_ready_s;
  logic [LANES*CW-1:0] lane_px_s;

  // Per-pixel greyscale rule; the average product saturates to the CW-bit range.
  function automatic logic [CW-1:0] grey_px(input logic [1:0] m, input logic [PW-1:0] px);
    logic [CW-1:0] r, g, b, mx, res;
    logic [CW+1:0] sum;
    logic [CW+8:0] prod, prod_sh, sat;
    r       = px[PW-1 -: CW];
    g       = px[2*CW-1 -: CW];
    b       = px[CW-1:0];
    sum     = {2'b00, r} + {2'b00, g} + {2'b00, b};
    prod    = {7'd0, sum} * {{(CW+2){1'b0}}, 7'd85};
    prod_sh = prod >> 4'd8;
    sat     = {9'd0, {CW{1'b1}}};
    mx      = (r > g) ? r : g;
    if (b > mx) mx = b;
    else        mx = mx;
    case (m)
      2'd0:    res = (r >> 2'd2) + (g >> 2'd1) + (b >> 2'd2);
      2'd1:    res = (prod_sh > sat) ? {CW{1'b1}} : prod_sh[CW-1:0];
      2'd2:    res = mx;
      2'd3:    res = g;
      default: res = g;
    endcase
    return res;
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_nx_s = state_r;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    handoff_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          accept_s   = 1'b1;
          state_nx_s = CONV;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        if (g_r == G_LAST) state_nx_s = HOLD;
        else               state_nx_s = CONV;
      end
      HOLD: begin
        // Downstream acceptance frees the buffer, so a new column can enter in the same cycle.
        in_ready_s = out_ready;
        if (out_ready) begin
          handoff_s = 1'b1;
          if (in_valid) begin
            accept_s   = 1'b1;
            state_nx_s = CONV;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Converters for the current group of LANES pixels of the latched column.
  always_comb begin
    lane_px_s = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_px_s[l*CW +: CW] = grey_px(mode_r, data_r[(int'(g_r) * LANES + l) * PW +: PW]);
    end
  end

  // State register and group counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      g_r     <= '0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        g_r <= '0;
      end else if (state_r == CONV && g_r != G_LAST) begin
        g_r <= g_r + 1'b1;
      end else begin
        g_r <= g_r;
      end
    end
  end

  // Input column, mode and last flag latched at accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_r <= '0;
      mode_r <= 2'd0;
      last_r <= 1'b0;
    end else if (accept_s) begin
      data_r <= in_data;
      mode_r <= mode;
      last_r <= in_last;
    end else begin
      data_r <= data_r;
      mode_r <= mode_r;
      last_r <= last_r;
    end
  end

  // Grey column buffer, written one group per CONV cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_r <= '0;
    end else if (state_r == CONV) begin
      out_data_r[int'(g_r) * LANES * CW +: LANES * CW] <= lane_px_s;
    end else begin
      out_data_r <= out_data_r;
    end
  end

  // Column counter, cleared by the handoff of a frame's last column.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (handoff_s) begin
      cnt_r <= last_r ? '0 : cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == HOLD);
  assign out_last  = last_r;
  assign out_data  = out_data_r;
  assign col_count = cnt_r;

endmodule

// File: tb/tb_grey_col_conv.sv
// Bench for grey_col_conv: table of uniform-pixel columns, random columns against a reference
// model, and hand sequences for latency, backpressure, mid-conversion reset and frame end.
module tb_grey_col_conv;

  localparam int N = 256, LANES = 32, CW = 8, CNT_W = 16, P = N / LANES, PW = 3 * CW;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic              in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [N*PW-1:0]   in_data = '0;
  logic              out_valid, out_ready = 1'b1, out_last;
  logic [N*CW-1:0]   out_data;
  logic [CNT_W-1:0]  col_count;

  always #5 clock = ~clock;

  grey_col_conv #(.N(N), .LANES(LANES), .CW(CW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_data(out_data),
    .col_count(col_count)
  );

  typedef struct { logic [N*CW-1:0] data; logic last; } exp_t;
  typedef struct { logic [1:0] m; logic [CW-1:0] r, g, b, exp; } vec_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  vec_t             vecs[12];
  int               errors = 0, checks = 0, cyc = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  bit               mon_en = 1'b0;

  function automatic logic [CW-1:0] model_px(input logic [1:0] m, input int r, input int g, input int b);
    int v;
    case (m)
      2'd0: v = r / 4 + g / 2 + b / 4;
      2'd1: begin v = ((r + g + b) * 85) / 256; if (v > (1 << CW) - 1) v = (1 << CW) - 1; end
      2'd2: begin v = r; if (g > v) v = g; if (b > v) v = b; end
      default: v = g;
    endcase
    return v[CW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_col(input string name, input logic [N*CW-1:0] exp);
    checks++;
    if (out_data !== exp) begin
      errors++;
      for (int i = 0; i < N; i++) begin
        if (out_data[i*CW +: CW] !== exp[i*CW +: CW]) begin
          $display("FAIL %s: pixel %0d got %0d expected %0d", name, i, out_data[i*CW +: CW], exp[i*CW +: CW]);
          break;
        end
      end
    end
  endtask

  task automatic uniform_col(input vec_t v, output logic [N*PW-1:0] d, output exp_t e);
    for (int i = 0; i < N; i++) begin
      d[i*PW +: PW]      = {v.r, v.g, v.b};
      e.data[i*CW +: CW] = v.exp;
    end
    e.last = 1'b0;
  endtask

  task automatic rand_col(input logic [1:0] m, input logic l, output logic [N*PW-1:0] d, output exp_t e);
    int r, g, b;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      d[i*PW +: PW]      = {r[CW-1:0], g[CW-1:0], b[CW-1:0]};
      e.data[i*CW +: CW] = model_px(m, r, g, b);
    end
    e.last = l;
  endtask

  // Drive a column until accepted; expectation is queued at the accepting cycle.
  task automatic send(input logic [N*PW-1:0] d, input logic [1:0] m, input exp_t e);
    int n = 0;
    in_data = d; in_last = e.last; mode = m; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 200) begin n++; @(negedge clock); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %0d after %0d cycles", in_ready, n);
    end else begin
      sb_q.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(negedge clock); n++; end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d columns pending, expected 0", sb_q.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic check_latency(input string name);
    for (int i = 1; i <= P + 1; i++) begin
      @(negedge clock);
      check(name, out_valid, (i == P + 1));
    end
  endtask

  // Scoreboard monitor: counter model, handoff data and last flag.
  always @(negedge clock) begin
    cyc++;
    if (mon_en) begin
      check("col_count", col_count, exp_cnt);
      if (reset) begin
        sb_q.delete();
        exp_cnt = '0;
      end else if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_handoff: got handoff expected none");
        end else begin
          mon_e = sb_q.pop_front();
          check_col("handoff_data", mon_e.data);
          check("out_last", out_last, mon_e.last);
          exp_cnt = mon_e.last ? '0 : exp_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    logic [N*PW-1:0] d;
    exp_t e, e2;
    int t0;
    vecs[0]  = '{2'd0, 8'd255, 8'd255, 8'd255, 8'd253};
    vecs[1]  = '{2'd0, 8'd200, 8'd100, 8'd40,  8'd110};
    vecs[2]  = '{2'd1, 8'd30,  8'd60,  8'd90,  8'd59};
    vecs[3]  = '{2'd2, 8'd30,  8'd60,  8'd90,  8'd90};
    vecs[4]  = '{2'd3, 8'd30,  8'd60,  8'd90,  8'd60};
    vecs[5]  = '{2'd1, 8'd255, 8'd255, 8'd255, 8'd254};
    vecs[6]  = '{2'd2, 8'd10,  8'd250, 8'd3,   8'd250};
    vecs[7]  = '{2'd0, 8'd0,   8'd0,   8'd0,   8'd0};
    vecs[8]  = '{2'd1, 8'd1,   8'd1,   8'd1,   8'd0};
    vecs[9]  = '{2'd1, 8'd100, 8'd0,   8'd0,   8'd33};
    vecs[10] = '{2'd2, 8'd200, 8'd7,   8'd9,   8'd200};
    vecs[11] = '{2'd0, 8'd3,   8'd1,   8'd3,   8'd0};

    // Reset then idle.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check_col("reset_out_data", '0);
    repeat (3) begin
      @(negedge clock);
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
    end
    @(posedge clock); #1;

    // Mode 0 latency with all-255 pixels.
    uniform_col(vecs[0], d, e);
    send(d, vecs[0].m, e);
    check_latency("latency_mode0");
    drain(40);

    // Table of uniform columns.
    for (int v = 0; v < 12; v++) begin
      uniform_col(vecs[v], d, e);
      send(d, vecs[v].m, e);
      drain(40);
    end

    // Random columns per mode against the model.
    for (int m = 0; m < 4; m++) begin
      rand_col(m[1:0], 1'b0, d, e);
      send(d, m[1:0], e);
      drain(40);
    end

    // Mode toggled during CONV must not affect the column.
    uniform_col(vecs[2], d, e);
    send(d, 2'd1, e);
    mode = 2'd2;
    @(posedge clock); #1 mode = 2'd0;
    drain(40);

    // Backpressure in HOLD with a pending column.
    out_ready = 1'b0;
    rand_col(2'd2, 1'b0, d, e);
    send(d, 2'd2, e);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clock);
    check("bp_out_valid", out_valid, 1);
    rand_col(2'd0, 1'b0, d, e2);
    in_data = d; in_last = 1'b0; mode = 2'd0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check_col("bp_hold_data", e.data);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready", in_ready, 1);
    sb_q.push_back(e2);
    @(posedge clock); #1 in_valid = 1'b0;
    check_latency("bp_latency");
    drain(40);

    // Reset in the middle of conversion (g == 3).
    rand_col(2'd1, 1'b1, d, e);
    send(d, 2'd1, e);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_col_count", col_count, 0);
    check_col("midrst_out_data", '0);
    @(posedge clock); #1 reset = 1'b0;
    rand_col(2'd3, 1'b0, d, e);
    send(d, 2'd3, e);
    check_latency("midrst_latency");
    drain(40);

    // Back-to-back frame of 4 columns, last on the 4th.
    t0 = cyc;
    for (int c = 0; c < 4; c++) begin
      rand_col(c[1:0], (c == 3), d, e);
      send(d, c[1:0], e);
    end
    drain(60);
    check("frame_col_count", col_count, 0);
    checks++;
    if (cyc - t0 > 4 * (P + 1) + 3) begin
      errors++;
      $display("FAIL frame_throughput: got %0d cycles expected at most %0d", cyc - t0, 4 * (P + 1) + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
